// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/flag/memory-ack inputs, datapath controls and status.
// master = the controller, slave = the datapath (or bench) that drives inputs and consumes controls.
interface multicycle_controller_if;
   logic       start;
   logic [7:0] instruction;
   logic       zero;
   logic       mem_ack;

   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       reg_write;
   logic       reg_dst;
   logic       alu_src;
   logic [1:0] alu_op;
   logic       mem_req;
   logic       mem_we;
   logic       mem_to_reg;

   logic       busy;
   logic       halted;
   logic       fault;
   logic [2:0] state;
   logic [7:0] instr_count;

   modport master (
      input  start, instruction, zero, mem_ack,
      output pc_write, pc_src, ir_write, reg_write, reg_dst, alu_src, alu_op,
             mem_req, mem_we, mem_to_reg, busy, halted, fault, state, instr_count
   );

   modport slave (
      output start, instruction, zero, mem_ack,
      input  pc_write, pc_src, ir_write, reg_write, reg_dst, alu_src, alu_op,
             mem_req, mem_we, mem_to_reg, busy, halted, fault, state, instr_count
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a MEM-ack timeout into FAULT.
// Instruction latency 2..5+w cycles; MEM holds mem_req until mem_ack or timeout.
module multicycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   multicycle_controller_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [2:0] OP_R    = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_J    = 3'b101;
   localparam logic [2:0] OP_NOP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [2:0] opcode_q, opcode_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] cnt_q, cnt_d;
   logic       retire;

   logic       pcw, irw, rw, rd, as, mr, mw, m2r;
   logic [1:0] pcs, aop;
   logic       unused_instr;

   assign unused_instr = ^bus.instruction[4:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opcode_q <= 3'b000;
         wait_q   <= 8'd0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         wait_q   <= wait_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      wait_d   = 8'd0;
      cnt_d    = cnt_q;
      retire   = 1'b0;
      pcw = 1'b0; pcs = 2'b00; irw = 1'b0; rw = 1'b0; rd = 1'b0;
      as  = 1'b0; aop = 2'b00; mr  = 1'b0; mw = 1'b0; m2r = 1'b0;

      case (state_q)
         S_IDLE: if (bus.start) state_d = S_FETCH;
         S_FETCH: begin
            irw     = 1'b1;
            pcw     = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            opcode_d = bus.instruction[7:5];
            case (bus.instruction[7:5])
               OP_HALT: state_d = S_HALT;
               OP_NOP: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode_q)
               OP_R: begin
                  aop     = 2'b10;
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  as      = 1'b1;
                  state_d = S_WB;
               end
               OP_LW, OP_SW: begin
                  as      = 1'b1;
                  state_d = S_MEM;
               end
               OP_BEQ: begin
                  aop    = 2'b01;
                  retire = 1'b1;
                  if (bus.zero) begin
                     pcw = 1'b1;
                     pcs = 2'b01;
                  end
               end
               OP_J: begin
                  pcw    = 1'b1;
                  pcs    = 2'b10;
                  retire = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mr = 1'b1;
            mw = (opcode_q == OP_SW);
            if (bus.mem_ack) begin
               if (opcode_q == OP_SW) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == TIMEOUT) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            rw      = 1'b1;
            rd      = (opcode_q == OP_R);
            m2r     = (opcode_q == OP_LW);
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: ;
      endcase

      if (retire) cnt_d = cnt_q + 8'd1;
   end

   // Reset blanks every control and status flag combinationally, not just from the next edge.
   assign bus.pc_write    = ~reset & pcw;
   assign bus.pc_src      = reset ? 2'b00 : pcs;
   assign bus.ir_write    = ~reset & irw;
   assign bus.reg_write   = ~reset & rw;
   assign bus.reg_dst     = ~reset & rd;
   assign bus.alu_src     = ~reset & as;
   assign bus.alu_op      = reset ? 2'b00 : aop;
   assign bus.mem_req     = ~reset & mr;
   assign bus.mem_we      = ~reset & mw;
   assign bus.mem_to_reg  = ~reset & m2r;
   assign bus.busy        = ~reset & (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
   assign bus.halted      = ~reset & (state_q == S_HALT);
   assign bus.fault       = ~reset & (state_q == S_FAULT);
   assign bus.state       = state_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: per-instruction expected traces from the opcode/latency rules, checked by a monitor.
module tb_multicycle_controller;
   localparam int TMO = 15;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   multicycle_controller_if bus();

   multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       pcw;
      logic [1:0] pcs;
      logic       irw, rw, rd, as;
      logic [1:0] aop;
      logic       mr, mw, m2r, busy, halted, fault;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic [7:0] m_cnt;
   exp_t mon_e, mon_a;

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         mon_a = '0;
         mon_a.st = bus.state;       mon_a.pcw = bus.pc_write;   mon_a.pcs = bus.pc_src;
         mon_a.irw = bus.ir_write;   mon_a.rw = bus.reg_write;   mon_a.rd = bus.reg_dst;
         mon_a.as = bus.alu_src;     mon_a.aop = bus.alu_op;     mon_a.mr = bus.mem_req;
         mon_a.mw = bus.mem_we;      mon_a.m2r = bus.mem_to_reg; mon_a.busy = bus.busy;
         mon_a.halted = bus.halted;  mon_a.fault = bus.fault;    mon_a.cnt = bus.instr_count;
         n_cmp = n_cmp + 1;
         if (mon_a !== mon_e) begin
            n_bad = n_bad + 1;
            $display("FAIL cycle_%0d: actual=%h (state %0d cnt %0d) required=%h (state %0d cnt %0d)",
                     cyc, mon_a, mon_a.st, mon_a.cnt, mon_e, mon_e.st, mon_e.cnt);
         end
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic exp_t mk(input logic [2:0] st);
      exp_t e = '0;
      e.st     = st;
      e.busy   = (st >= 3'd1) && (st <= 3'd5);
      e.halted = (st == 3'd6);
      e.fault  = (st == 3'd7);
      e.cnt    = m_cnt;
      return e;
   endfunction

   task automatic drive(input logic rst, input logic s, input logic [7:0] ins,
                        input logic z, input logic ack, input exp_t e);
      reset = rst; bus.start = s; bus.instruction = ins; bus.zero = z; bus.mem_ack = ack;
      q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // First reset cycle still shows the pre-reset state and count; controls/flags are blanked.
   task automatic do_reset(input logic [2:0] cur_st, input int n);
      exp_t e = '0;
      e.st  = cur_st;
      e.cnt = m_cnt;
      drive(1'b1, 1'b1, 8'($urandom), rb(), 1'b1, e);
      m_cnt = 8'd0;
      for (int i = 1; i < n; i++) drive(1'b1, rb(), 8'($urandom), rb(), 1'b1, '0);
   endtask

   task automatic idle_start();
      drive(1'b0, 1'b1, 8'($urandom), rb(), 1'b0, mk(3'd0));
   endtask

   task automatic absorb(input logic [2:0] st, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 8'($urandom), rb(), rb(), mk(st));
   endtask

   // w = MEM cycles without ack before the ack (<0: never); rst_mem = MEM cycle index that gets reset.
   task automatic do_instr(input logic [7:0] ins, input logic z, input int w, input int rst_mem);
      logic [2:0] op = ins[7:5];
      exp_t e;
      logic ack;
      e = mk(3'd1); e.irw = 1'b1; e.pcw = 1'b1;
      drive(1'b0, rb(), ins, rb(), 1'b0, e);
      drive(1'b0, rb(), ins, rb(), 1'b0, mk(3'd2));
      if (op == 3'b111) return;
      if (op == 3'b110) begin
         m_cnt = m_cnt + 8'd1;
         return;
      end
      e = mk(3'd3);
      case (op)
         3'b000: e.aop = 2'b10;
         3'b001, 3'b010, 3'b011: e.as = 1'b1;
         3'b100: begin
            e.aop = 2'b01; e.pcw = z; e.pcs = z ? 2'b01 : 2'b00;
         end
         default: begin
            e.pcw = 1'b1; e.pcs = 2'b10;
         end
      endcase
      drive(1'b0, rb(), 8'($urandom), (op == 3'b100) ? z : rb(), 1'b0, e);
      if (op == 3'b100 || op == 3'b101) begin
         m_cnt = m_cnt + 8'd1;
         return;
      end
      if (op == 3'b010 || op == 3'b011) begin
         for (int i = 0; i <= TMO; i++) begin
            if (i == rst_mem) begin
               do_reset(3'd4, 1);
               return;
            end
            ack = (i == w);
            e = mk(3'd4); e.mr = 1'b1; e.mw = (op == 3'b011);
            drive(1'b0, rb(), 8'($urandom), rb(), ack, e);
            if (ack) begin
               if (op == 3'b011) begin
                  m_cnt = m_cnt + 8'd1;
                  return;
               end
               break;
            end
            if (i == TMO) return;
         end
      end
      e = mk(3'd5); e.rw = 1'b1; e.rd = (op == 3'b000); e.m2r = (op == 3'b010);
      drive(1'b0, rb(), 8'($urandom), rb(), 1'b0, e);
      m_cnt = m_cnt + 8'd1;
   endtask

   initial begin
      reset = 1'b1; bus.start = 1'b0; bus.instruction = 8'h00; bus.zero = 1'b0; bus.mem_ack = 1'b0;
      m_cnt = 8'd0;
      @(posedge clock);
      #1;
      do_reset(3'd0, 2);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(3'd0));
      idle_start();
      do_instr(8'b000_01_010, rb(), 0, -1);
      do_instr({3'b010, 5'($urandom)}, 1'b0, 3, -1);
      do_instr({3'b100, 5'($urandom)}, 1'b1, 0, -1);
      do_instr({3'b100, 5'($urandom)}, 1'b0, 0, -1);
      do_instr({3'b001, 5'($urandom)}, 1'b0, 0, -1);
      do_instr({3'b101, 5'($urandom)}, 1'b0, 0, -1);
      do_instr({3'b011, 5'($urandom)}, 1'b0, 2, -1);
      do_instr({3'b011, 5'($urandom)}, 1'b0, 0, -1);
      do_instr({3'b110, 5'($urandom)}, 1'b0, 0, -1);
      for (int k = 0; k < 40; k++)
         do_instr({3'($urandom_range(0, 6)), 5'($urandom)}, rb(), int'($urandom_range(0, 6)), -1);

      do_instr({3'b011, 5'($urandom)}, 1'b0, -1, -1);
      absorb(3'd7, 3);
      do_reset(3'd7, 1);
      idle_start();

      do_instr({3'b001, 5'($urandom)}, 1'b0, 0, -1);
      do_instr({3'b010, 5'($urandom)}, 1'b0, 5, 1);
      drive(1'b0, 1'b0, 8'($urandom), rb(), 1'b0, mk(3'd0));
      idle_start();

      for (int k = 0; k < 256; k++) do_instr({3'b110, 5'($urandom)}, rb(), 0, -1);
      do_instr({3'b111, 5'($urandom)}, rb(), 0, -1);
      absorb(3'd6, 3);
      do_reset(3'd6, 1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, mk(3'd0));

      for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clock);
      if (q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL drain: actual=%0d pending required=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
